// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles into NIBBLES-wide words, first nibble in the LSBs.
// A word is emitted when it fills or when in_last closes a packet early.
module nibble_packer #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [3:0]   in_nibble,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_word,
  output logic [3:0]   out_count,
  output logic         out_last,
  input  logic         out_ready,
  output logic [2:0]   fill_state
);

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // Valid may not depend on ready; ready never depends on the same-side valid or data.
  typedef enum logic [2:0] {
    FILL_0, FILL_1, FILL_2, FILL_3, FILL_4, FILL_5, FILL_6, FILL_7
  } fill_e;

  localparam fill_e LAST_FILL = fill_e'(NIBBLES - 1);

  fill_e        cnt, cnt_n;
  logic [W-1:0] acc, acc_n;
  logic [W-1:0] merged;
  logic         take, completing;
  logic         out_valid_n, out_last_n;
  logic [W-1:0] out_word_n;
  logic [3:0]   out_count_n;

  assign fill_state = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= FILL_0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_count <= 4'd0;
      out_last  <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      acc       <= acc_n;
      out_valid <= out_valid_n;
      out_word  <= out_word_n;
      out_count <= out_count_n;
      out_last  <= out_last_n;
    end
  end

  always_comb begin
    in_ready    = !rst && (!out_valid || out_ready);
    take        = in_valid && in_ready;
    completing  = take && ((cnt == LAST_FILL) || in_last);

    // Unfilled upper nibbles of acc are always zero, so merging needs no mask.
    merged                    = acc;
    merged[4*int'(cnt) +: 4]  = in_nibble;

    cnt_n       = cnt;
    acc_n       = acc;
    out_valid_n = out_valid;
    out_word_n  = out_word;
    out_count_n = out_count;
    out_last_n  = out_last;

    if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end

    // A completing nibble reloads the output register even as the old word leaves.
    if (take) begin
      if (completing) begin
        out_valid_n = 1'b1;
        out_word_n  = merged;
        out_count_n = {1'b0, cnt} + 4'd1;
        out_last_n  = in_last;
        acc_n       = '0;
        cnt_n       = FILL_0;
      end else begin
        acc_n = merged;
        cnt_n = fill_e'(cnt + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: driver tasks push expected words into a queue,
// an independent monitor pops and compares on every output transfer.
module tb_nibble_packer;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   in_nibble;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_word;
  logic [3:0]   out_count;
  logic         out_last;
  logic         out_ready;
  logic [2:0]   fill_state;

  // Expected entries are {last, count, word}.
  logic [W+4:0] exp_q[$];
  logic [W+4:0] exp_item;
  int vectors = 0;
  int miscompares = 0;
  int stall_cycles = 0;

  nibble_packer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_nibble(in_nibble), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_word(out_word), .out_count(out_count), .out_last(out_last),
    .out_ready(out_ready), .fill_state(fill_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic expect_word(input logic last, input logic [3:0] count, input logic [W-1:0] word);
    exp_q.push_back({last, count, word});
  endtask

  task automatic send(input logic [3:0] nib, input logic last);
    int waits;
    in_valid  = 1'b1;
    in_nibble = nib;
    in_last   = last;
    waits     = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      stall_cycles++;
      @(negedge clk);
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready got 0 want 1 after %0d cycles", waits);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got word %h count %0d last %0b want none",
                 out_word, out_count, out_last);
      end else begin
        exp_item = exp_q.pop_front();
        if ({out_last, out_count, out_word} !== exp_item) begin
          miscompares++;
          $display("FAIL out_word: got last %0b count %0d word %h want last %0b count %0d word %h",
                   out_last, out_count, out_word, exp_item[W+4], exp_item[W+3:W], exp_item[W-1:0]);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_nibble = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word",  32'(out_word),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_fill",      32'(fill_state), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // full word 1,2,3,4 with last on the fourth
    expect_word(1'b1, 4'd4, 16'h4321);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    check("fill_after_3", 32'(fill_state), 32'd3);
    send(4'h4, 1'b1);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("fill_wrap", 32'(fill_state), 32'd0);

    // short packet A,B
    expect_word(1'b1, 4'd2, 16'h00BA);
    send(4'hA, 1'b0);
    send(4'hB, 1'b1);
    check("short_valid", 32'(out_valid), 32'd1);

    // back-to-back 0..7, no stalls allowed
    expect_word(1'b0, 4'd4, 16'h3210);
    expect_word(1'b1, 4'd4, 16'h7654);
    stall_cycles = 0;
    for (int i = 0; i < 8; i++) send(4'(i), i == 7);
    check("b2b_stalls", 32'(stall_cycles), 32'd0);
    check("b2b_valid", 32'(out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // backpressure hold
    out_ready = 1'b0;
    expect_word(1'b1, 4'd1, 16'h000C);
    send(4'hC, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_word", 32'({out_last, out_count, out_word}), 32'({1'b1, 4'd1, 16'h000C}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // reset mid-word discards 5,6
    expect_word(1'b1, 4'd1, 16'h0009);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    check("mid_fill", 32'(fill_state), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_fill", 32'(fill_state), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    send(4'h9, 1'b1);

    // last on every nibble
    expect_word(1'b1, 4'd1, 16'h000F);
    expect_word(1'b1, 4'd1, 16'h000E);
    expect_word(1'b1, 4'd1, 16'h000D);
    send(4'hF, 1'b1);
    send(4'hE, 1'b1);
    send(4'hD, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per output word (legal range 2..8).
REQ-002 The block SHALL have derived width W = 4*NIBBLES, default 16, giving the output word width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: the upstream nibble is valid.
REQ-006 Port in_nibble, input, [3:0]: nibble data, bit 0 = a0 ... bit 3 = a3 from the upstream concat stage.
REQ-007 Port in_last, input, 1: marks the current nibble as the final one of a packet.
REQ-008 Port in_ready, output, 1: the block accepts a nibble this cycle.
REQ-009 Port out_valid, output, 1: out_word, out_count and out_last are valid.
REQ-010 Port out_word, output, [W-1:0]: the packed word.
REQ-011 Port out_count, output, [3:0]: the number of valid nibbles in out_word (1..NIBBLES).
REQ-012 Port out_last, output, 1: out_word closes a packet.
REQ-013 Port out_ready, input, 1: downstream accepts the word.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal !rst && (!out_valid || out_ready), combinational, and SHALL NOT depend on in_valid, in_nibble or in_last.
REQ-016 The internal fill counter cnt (0..NIBBLES-1) SHALL be the state: FILL_k means k nibbles are held in the accumulator acc[W-1:0].
REQ-017 The k-th accepted nibble of a word (k from 0) SHALL be placed at acc[4k+3:4k], so the first nibble is the LSBs, matching {a3,a2,a1,a0} ordering extended across time.
REQ-018 An accepted nibble SHALL complete the word when cnt==NIBBLES-1 or in_last==1.
REQ-019 On a completing transfer, the next cycle SHALL have: out_valid=1; out_word = acc with the new nibble merged and all unfilled upper nibbles 0; out_count=cnt+1; out_last=in_last; acc cleared; cnt=0.
REQ-020 On a non-completing transfer, acc SHALL update and cnt SHALL increment; the output register SHALL be unchanged.
REQ-021 Latency from the completing input transfer to out_valid SHALL be exactly 1 cycle.
REQ-022 An output transfer without a same-cycle completing input SHALL clear out_valid next cycle.
REQ-023 An output transfer in the same cycle as a completing input SHALL reload the output register, holding out_valid=1 with no bubble, giving full throughput.
REQ-024 While out_valid && !out_ready, in_ready SHALL be 0, and out_word, out_count and out_last SHALL hold stable.
REQ-025 in_last on the first nibble SHALL produce out_count=1, with only out_word[3:0] non-zero.
REQ-026 in_last coinciding with cnt==NIBBLES-1 SHALL produce a single word with out_count=NIBBLES and out_last=1, and no extra empty word.
REQ-027 cnt SHALL wrap NIBBLES-1 -> 0 only via a completing transfer and SHALL never exceed NIBBLES-1.

Reset
REQ-028 While rst=1, the block SHALL force: out_valid=0, out_word=0, out_count=0, out_last=0, in_ready=0, acc=0, cnt=0.
REQ-029 Reset asserted mid-word SHALL discard the partial accumulator and any pending output word; no word SHALL be emitted for it.
REQ-030 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification
REQ-031 Nibbles 1,2,3,4 with in_last on the 4th, out_ready=1 -> one cycle later: out_word=16'h4321, out_count=4, out_last=1.
REQ-032 Nibbles A,B with in_last on B -> out_word=16'h00BA, out_count=2, out_last=1.
REQ-033 8 back-to-back nibbles 0..7, out_ready=1, in_last on 7 -> words 16'h3210 (last=0) then 16'h7654 (last=1) on consecutive output cycles, in_ready stuck at 1.
REQ-034 out_ready=0 with a word pending -> in_ready=0 and the word held stable for 5 cycles; then out_ready=1 -> transfer occurs and in_ready returns to 1 the same cycle.
REQ-035 Nibbles 5,6 accepted, rst pulsed 1 cycle, then 9 with in_last -> out_word=16'h0009, out_count=1, and no word containing 5 or 6 is ever emitted.
REQ-036 in_last on every nibble (F,E,D) -> three words 16'h000F, 16'h000E, 16'h000D, each with out_count=1 and out_last=1.
